// File: rtl/exmem_pkg.sv
// exmem_pkg: shared types for the EX/MEM skid stage.
//   ctrl_t        - memory/writeback control, MSB first:
//                   {regwrite, memread, memwrite, memtoreg, branch, uncond_branch}
//   exmem_state_t - occupancy of the two-entry skid buffer
//   entry_t       - one captured EX result at the default widths
//   branch_taken  - CBZ/B resolution from control and zero flag
package exmem_pkg;

   localparam int unsigned DATA_W_DEFAULT = 64;
   localparam int unsigned REG_W_DEFAULT  = 5;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic branch;
      logic uncond_branch;
   } ctrl_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } exmem_state_t;

   typedef struct packed {
      logic [DATA_W_DEFAULT-1:0] result;
      logic                      zero;
      logic [DATA_W_DEFAULT-1:0] write_data;
      logic [REG_W_DEFAULT-1:0]  rd;
      ctrl_t                     ctrl;
      logic [DATA_W_DEFAULT-1:0] branch_target;
   } entry_t;

   // Unconditional B always redirects; CBZ redirects only on a zero result.
   function automatic logic branch_taken(input ctrl_t c, input logic zero);
      return c.uncond_branch | (c.branch & zero);
   endfunction

endpackage

// File: rtl/exmem_entry.sv
// exmem_entry: one payload register of the EX/MEM skid buffer.
// Ports:
//   i_clk   - rising-edge clock
//   i_rst_n - asynchronous active-low clear (contents forced to zero)
//   i_load  - capture i_d on the next rising edge
//   i_d     - entry to capture
//   o_q     - held entry
module exmem_entry
   import exmem_pkg::*;
#(
   parameter type entry_type_t = entry_t
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  entry_type_t i_d,
   output entry_type_t o_q
);

   entry_type_t r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: LEGv8 execute-to-memory stage built as a 2-entry skid buffer.
// Captures ALU result, zero flag, store data, destination register, control and
// branch target; resolves CBZ/B from the head entry; supports synchronous flush.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   in_valid/in_ready       - upstream handshake (in_ready is registered)
//   alu_result, alu_zero, write_data, rd, ctrl, branch_target - upstream payload
//   flush                   - discard every held entry (wins over accept/release)
//   out_valid/out_ready     - downstream handshake
//   out_*                   - head entry payload
//   pc_src                  - head entry is a taken branch
// Build option EXMEM_FWD_EN: adds fwd_valid/fwd_rd/fwd_result for EX forwarding.
module ex_mem_skid
   import exmem_pkg::*;
#(
   parameter int unsigned N     = DATA_W_DEFAULT,
   parameter int unsigned REG_W = REG_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     alu_result,
   input  logic             alu_zero,
   input  logic [N-1:0]     write_data,
   input  logic [REG_W-1:0] rd,
   input  logic [5:0]       ctrl,
   input  logic [N-1:0]     branch_target,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_result,
   output logic [N-1:0]     out_write_data,
   output logic [N-1:0]     out_branch_target,
   output logic             out_zero,
   output logic [REG_W-1:0] out_rd,
   output logic [5:0]       out_ctrl,
   output logic             pc_src
`ifdef EXMEM_FWD_EN
   ,
   output logic             fwd_valid,
   output logic [REG_W-1:0] fwd_rd,
   output logic [N-1:0]     fwd_result
`endif
);

   // Same layout as entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic [N-1:0]     result;
      logic             zero;
      logic [N-1:0]     write_data;
      logic [REG_W-1:0] rd;
      ctrl_t            ctrl;
      logic [N-1:0]     branch_target;
   } slot_t;

   exmem_state_t r_state;
   exmem_state_t w_state_next;
   logic         r_in_ready;
   logic         w_accept;
   logic         w_release;
   logic         w_load_main;
   logic         w_load_skid;
   slot_t        w_in_entry;
   slot_t        w_main_d;
   slot_t        w_main_q;
   slot_t        w_skid_q;

   assign w_in_entry = '{
      result:        alu_result,
      zero:          alu_zero,
      write_data:    write_data,
      rd:            rd,
      ctrl:          ctrl_t'(ctrl),
      branch_target: branch_target
   };

   assign out_valid = (r_state != EMPTY);
   assign in_ready  = r_in_ready;
   assign w_accept  = in_valid & r_in_ready;
   assign w_release = out_valid & out_ready;

   // Main refills from the skid entry when draining FULL, otherwise from upstream.
   assign w_main_d = (r_state == FULL) ? w_skid_q : w_in_entry;

   always_comb begin
      w_state_next = r_state;
      w_load_main  = 1'b0;
      w_load_skid  = 1'b0;
      if (flush) begin
         w_state_next = EMPTY;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_load_main  = 1'b1;
                  w_state_next = ONE;
               end
            end
            ONE: begin
               if (w_accept && !w_release) begin
                  w_load_skid  = 1'b1;
                  w_state_next = FULL;
               end else if (w_accept && w_release) begin
                  w_load_main  = 1'b1;
               end else if (w_release) begin
                  w_state_next = EMPTY;
               end
            end
            FULL: begin
               if (w_release) begin
                  w_load_main  = 1'b1;
                  w_state_next = ONE;
               end
            end
            default: begin
               w_state_next = EMPTY;
            end
         endcase
      end
   end

   // in_ready is derived from the next state so it is already low in the first
   // FULL cycle; out_ready reaches it only through the register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next != FULL);
      end
   end

   exmem_entry #(
      .entry_type_t (slot_t)
   ) u_main (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_load  (w_load_main),
      .i_d     (w_main_d),
      .o_q     (w_main_q)
   );

   exmem_entry #(
      .entry_type_t (slot_t)
   ) u_skid (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_load  (w_load_skid),
      .i_d     (w_in_entry),
      .o_q     (w_skid_q)
   );

   assign out_result        = w_main_q.result;
   assign out_write_data    = w_main_q.write_data;
   assign out_branch_target = w_main_q.branch_target;
   assign out_zero          = w_main_q.zero;
   assign out_rd            = w_main_q.rd;
   assign out_ctrl          = w_main_q.ctrl;
   assign pc_src            = out_valid & branch_taken(w_main_q.ctrl, w_main_q.zero);

`ifdef EXMEM_FWD_EN
   // Loads are excluded: their value is not known until the memory stage.
   assign fwd_valid  = out_valid & w_main_q.ctrl.regwrite & ~w_main_q.ctrl.memread;
   assign fwd_rd     = w_main_q.rd;
   assign fwd_result = w_main_q.result;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenario tasks plus a
// queue scoreboard that tracks accepted entries and checks every release.
module tb_ex_mem_skid;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] alu_result;
   logic        alu_zero;
   logic [63:0] write_data;
   logic [4:0]  rd;
   logic [5:0]  ctrl;
   logic [63:0] branch_target;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [63:0] out_write_data;
   logic [63:0] out_branch_target;
   logic        out_zero;
   logic [4:0]  out_rd;
   logic [5:0]  out_ctrl;
   logic        pc_src;
`ifdef EXMEM_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [63:0] fwd_result;
`endif

   typedef struct {
      logic [63:0] res;
      logic        zero;
      logic [63:0] wd;
      logic [4:0]  rd;
      logic [5:0]  ctrl;
      logic [63:0] tgt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   n_pop  = 0;

   ex_mem_skid dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .alu_result        (alu_result),
      .alu_zero          (alu_zero),
      .write_data        (write_data),
      .rd                (rd),
      .ctrl              (ctrl),
      .branch_target     (branch_target),
      .flush             (flush),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_result        (out_result),
      .out_write_data    (out_write_data),
      .out_branch_target (out_branch_target),
      .out_zero          (out_zero),
      .out_rd            (out_rd),
      .out_ctrl          (out_ctrl),
      .pc_src            (pc_src)
`ifdef EXMEM_FWD_EN
      ,
      .fwd_valid         (fwd_valid),
      .fwd_rd            (fwd_rd),
      .fwd_result        (fwd_result)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: at each falling edge the inputs are stable for the next rising
   // edge, so accept/release seen here is what the DUT will do at that edge.
   always @(negedge clk) begin
      exp_t h;
      logic exp_pc;
      if (!reset_n) begin
         sb.delete();
      end else begin
         checks++;
         if (out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL sb_out_valid: got %0b expected %0b", out_valid, sb.size() != 0);
         end
         checks++;
         if (in_ready !== (sb.size() < 2)) begin
            errors++;
            $display("FAIL sb_in_ready: got %0b expected %0b", in_ready, sb.size() < 2);
         end
         exp_pc = 1'b0;
         if (sb.size() != 0) begin
            exp_pc = sb[0].ctrl[0] | (sb[0].ctrl[1] & sb[0].zero);
         end
         checks++;
         if (pc_src !== exp_pc) begin
            errors++;
            $display("FAIL sb_pc_src: got %0b expected %0b", pc_src, exp_pc);
         end
`ifdef EXMEM_FWD_EN
         checks++;
         if (fwd_valid !== ((sb.size() != 0) && sb[0].ctrl[5] && !sb[0].ctrl[4])) begin
            errors++;
            $display("FAIL sb_fwd_valid: got %0b", fwd_valid);
         end
`endif
         if (flush) begin
            sb.delete();
         end else begin
            if (out_valid && out_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_release: got release of %0h expected no entry", out_result);
               end else begin
                  h = sb.pop_front();
                  n_pop++;
                  if (out_result !== h.res || out_zero !== h.zero || out_write_data !== h.wd ||
                      out_rd !== h.rd || out_ctrl !== h.ctrl || out_branch_target !== h.tgt) begin
                     errors++;
                     $display("FAIL sb_payload: got res=%0h z=%0b wd=%0h rd=%0d ctrl=%b tgt=%0h expected res=%0h z=%0b wd=%0h rd=%0d ctrl=%b tgt=%0h",
                              out_result, out_zero, out_write_data, out_rd, out_ctrl,
                              out_branch_target, h.res, h.zero, h.wd, h.rd, h.ctrl, h.tgt);
                  end
               end
            end
            if (in_valid && in_ready) begin
               sb.push_back('{res: alu_result, zero: alu_zero, wd: write_data, rd: rd,
                              ctrl: ctrl, tgt: branch_target});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [63:0] res, input logic z,
                         input logic [4:0] r, input logic [5:0] c);
      in_valid      = v;
      alu_result    = res;
      alu_zero      = z;
      write_data    = res ^ 64'hA5A5_0000_FFFF_1234;
      rd            = r;
      ctrl          = c;
      branch_target = {res[31:0], 32'h0000_0400};
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      set_in(1'b0, 64'h0, 1'b0, 5'd0, 6'b0);
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || pc_src !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got in_ready=%0b out_valid=%0b pc_src=%0b expected 1 0 0",
                  in_ready, out_valid, pc_src);
      end
      checks++;
      if (out_result !== 64'h0 || out_write_data !== 64'h0 || out_branch_target !== 64'h0 ||
          out_zero !== 1'b0 || out_rd !== 5'd0 || out_ctrl !== 6'b0) begin
         errors++;
         $display("FAIL reset_payload: got res=%0h rd=%0d ctrl=%b expected all zero",
                  out_result, out_rd, out_ctrl);
      end
      next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      next_cycle();
      out_ready = 1'b1;
      set_in(1'b1, 64'h10, 1'b0, 5'd3, 6'b100000);
      next_cycle();
      set_in(1'b0, 64'h0, 1'b0, 5'd0, 6'b0);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 64'h10 || out_rd !== 5'd3) begin
         errors++;
         $display("FAIL single_out: got valid=%0b res=%0h rd=%0d expected 1 10 3",
                  out_valid, out_result, out_rd);
      end
      next_cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got out_valid=%0b expected 0", out_valid);
      end
   endtask

   task automatic test_stream();
      int p0;
      p0 = n_pop;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 64'h100 + 64'(i), i[0], 5'(i + 8), 6'b100100);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready);
         end
         next_cycle();
      end
      set_in(1'b0, 64'h0, 1'b0, 5'd0, 6'b0);
      next_cycle();
      next_cycle();
      checks++;
      if (n_pop - p0 !== 8) begin
         errors++;
         $display("FAIL stream_count: got %0d expected 8", n_pop - p0);
      end
   endtask

   task automatic test_backpressure();
      int          idx;
      int          p0;
      logic [63:0] held;
      idx  = 0;
      p0   = n_pop;
      held = 64'h0;
      for (int c = 0; c < 14; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         set_in(idx < 8, 64'h200 + 64'(idx), 1'b0, 5'(idx), 6'b101000);
         @(negedge clk);
         if (c == 3) begin
            held = out_result;
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL bp_ready_before: got %0b expected 1", in_ready);
            end
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_ready_low[%0d]: got %0b expected 0", c, in_ready);
            end
            checks++;
            if (out_result !== held || out_result !== 64'h202) begin
               errors++;
               $display("FAIL bp_head_hold[%0d]: got %0h expected 202", c, out_result);
            end
         end
         if (in_valid && in_ready) idx++;
         next_cycle();
      end
      checks++;
      if (idx !== 8 || n_pop - p0 !== 8) begin
         errors++;
         $display("FAIL bp_count: got sent=%0d released=%0d expected 8 8", idx, n_pop - p0);
      end
   endtask

   task automatic test_branch();
      logic [5:0] c_tab [3];
      logic       z_tab [3];
      logic       pc_tab[3];
      c_tab  = '{6'b000010, 6'b000010, 6'b000001};
      z_tab  = '{1'b1, 1'b0, 1'b0};
      pc_tab = '{1'b1, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 64'h300 + 64'(i), z_tab[i], 5'd0, c_tab[i]);
         next_cycle();
         checks++;
         if (pc_src !== pc_tab[i] || out_result !== 64'h300 + 64'(i)) begin
            errors++;
            $display("FAIL branch_pc[%0d]: got pc_src=%0b head=%0h expected %0b %0h",
                     i, pc_src, out_result, pc_tab[i], 64'h300 + 64'(i));
         end
      end
      set_in(1'b0, 64'h0, 1'b0, 5'd0, 6'b0);
      next_cycle();
      checks++;
      if (pc_src !== 1'b0) begin
         errors++;
         $display("FAIL branch_idle: got %0b expected 0", pc_src);
      end
   endtask

   task automatic fill_two();
      out_ready = 1'b0;
      set_in(1'b1, 64'h400, 1'b0, 5'd1, 6'b100001);
      next_cycle();
      set_in(1'b1, 64'h401, 1'b1, 5'd2, 6'b100010);
      next_cycle();
      set_in(1'b0, 64'h0, 1'b0, 5'd0, 6'b0);
   endtask

   task automatic test_flush();
      fill_two();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_src !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre: got in_ready=%0b out_valid=%0b pc_src=%0b expected 0 1 1",
                  in_ready, out_valid, pc_src);
      end
      flush = 1'b1;
      set_in(1'b1, 64'hDEAD_BEEF, 1'b1, 5'd31, 6'b100001);
      next_cycle();
      flush = 1'b0;
      set_in(1'b0, 64'h0, 1'b0, 5'd0, 6'b0);
      checks++;
      if (out_valid !== 1'b0 || pc_src !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_post: got out_valid=%0b pc_src=%0b in_ready=%0b expected 0 0 1",
                  out_valid, pc_src, in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         checks++;
         if (out_valid !== 1'b0 || out_result === 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL flush_drop[%0d]: got valid=%0b res=%0h expected 0, not deadbeef",
                     i, out_valid, out_result);
         end
      end
   endtask

   task automatic test_async_reset();
      fill_two();
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_src !== 1'b0 || out_result !== 64'h0) begin
         errors++;
         $display("FAIL async_reset: got valid=%0b ready=%0b pc=%0b res=%0h expected 0 1 0 0",
                  out_valid, in_ready, pc_src, out_result);
      end
`ifdef EXMEM_FWD_EN
      checks++;
      if (fwd_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_fwd: got %0b expected 0", fwd_valid);
      end
`endif
      sb.delete();
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      next_cycle();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_branch();
      test_flush();
      test_async_reset();
      test_single();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Execute-to-memory boundary stage of the LEGv8 pipeline. It sits directly downstream of the 64-bit ALU and captures the ALU result, zero flag, store data, destination register and memory/writeback control into a 2-entry skid buffer with valid/ready handshakes on both sides. It also resolves CBZ/B branches from the captured zero flag and supports a synchronous pipeline flush.

## Interface
Parameters:
- N, 64, datapath width (ALU result, store data, branch target)
- REG_W, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered
- alu_result  in  N  ALU result
- alu_zero  in  1  ALU zero flag
- write_data  in  N  store data (Rt)
- rd  in  REG_W  destination register
- ctrl  in  6  {regwrite, memread, memwrite, memtoreg, branch, uncond_branch}
- branch_target  in  N  computed PC target
- flush  in  1  discard all held entries
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_result, out_write_data, out_branch_target  out  N  head fields
- out_zero  out  1  head zero flag
- out_rd  out  REG_W  head destination
- out_ctrl  out  6  head control
- pc_src  out  1  head branch taken

## Operation
- Storage: main entry (drives out_*) and skid entry. State is EMPTY, ONE or FULL.
- Accept: in_valid & in_ready. Release: out_valid & out_ready.
- EMPTY: accept loads main, then ONE.
- ONE:
  - Accept without release: load skid, then FULL.
  - Accept with release: load main, stay ONE.
  - Release only: EMPTY.
- FULL: in_ready=0. Release moves skid into main, then ONE. Upstream data is ignored.
- in_ready is registered. It is 1 in the cycle after the state is EMPTY or ONE, and 0 in the cycle after the state is FULL. No combinational path from out_ready to in_ready.
- out_valid = state != EMPTY.
- pc_src = out_valid & (uncond_branch | (branch & out_zero)). Combinational from the head entry only.
- flush:
  - Priority over accept and release.
  - Next state is EMPTY and in_ready is 1 next cycle.
  - An in_valid in the flush cycle is dropped.
  - Payload registers need not clear; out_valid and pc_src must be 0.
- Head payload is stable while out_valid & !out_ready (AXI-style hold).
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Reset (async assert, sync-released by the system): state EMPTY, in_ready=1, out_valid=0, pc_src=0, all out_* payload 0.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency: accept at edge k gives out_valid=1 after edge k, when the stage was empty.
- Throughput: 1 entry/cycle while out_ready stays high.
- Back-pressure: one stalled cycle of out_ready fills the skid entry; in_ready falls on the following edge. No entry is lost or duplicated.
- Simultaneous accept+release in FULL cannot occur because in_ready=0.

## Configuration
- EXMEM_FWD_EN defined: adds ports fwd_valid (out 1), fwd_rd (out REG_W), fwd_result (out N). These equal out_valid & out_ctrl.regwrite & !out_ctrl.memread, out_rd and out_result, and feed the EX forwarding unit.
- Undefined: these ports do not exist and no forwarding logic is built.

## Structure
- Package exmem_pkg: ctrl_t packed struct (6 control bits, order as above), exmem_state_t enum {EMPTY, ONE, FULL}, REG_W default constant, and entry_t struct {result, zero, write_data, rd, ctrl, branch_target}.
- One sub-module, exmem_entry: an entry_t register with load enable and async active-low clear. It is instantiated twice (main, skid).

## Test plan
- Reset, then one entry: result=0x10, zero=0, rd=3, out_ready=1 → out_valid=1 one cycle later with out_result=0x10, out_rd=3; out_valid=0 the cycle after.
- Streaming: 8 entries on consecutive cycles with out_ready=1 → 8 outputs in order, one per cycle; in_ready stays 1.
- Back-pressure: out_ready=0 for 3 cycles during a stream → in_ready falls after the second held entry. Head is stable; no loss; order is preserved after release.
- Branch: ctrl.branch=1, zero=1 → pc_src=1 while the entry is the head. zero=0 → pc_src=0. uncond_branch=1 → pc_src=1 regardless of zero.
- Flush while FULL, with in_valid=1 in the same cycle → next cycle out_valid=0, pc_src=0, in_ready=1. The flushed-cycle input never appears at the output.
- reset_n pulsed low while FULL, between clock edges → out_valid=0 and in_ready=1 immediately. With EXMEM_FWD_EN defined, fwd_valid=0.
